alu_8bit: RTL and testbench
===========================

ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, data-path width in bits; all requirements below use WIDTH=8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port InsSel, input, 2 bits: operation select.
REQ-005 The block SHALL have port ALUinA, input, 8 bits: operand A, unsigned.
REQ-006 The block SHALL have port ALUinB, input, 8 bits: operand B, unsigned.
REQ-007 The block SHALL have port ALUout, output, 8 bits: registered result.
REQ-008 The block SHALL have port CO, output, 1 bit: registered carry/borrow flag.
REQ-009 The block SHALL have port Z, output, 1 bit: registered zero flag.

Function
REQ-010 The block SHALL decode InsSel as follows: 2'b00 = ADD (A+B), 2'b01 = SUB (A-B), 2'b10 = AND (A&B), 2'b11 = OR (A|B).
REQ-011 The block SHALL compute the result combinationally from InsSel, ALUinA and ALUinB, and register the result into ALUout, CO and Z on each rising clk edge while rst_n is high.
REQ-012 The block SHALL have a latency of exactly one clock: outputs after edge n reflect the inputs sampled at edge n.
REQ-013 The block SHALL accept new operands and a new opcode on every cycle, with no handshake, no stall and no enable.
REQ-014 ADD SHALL produce ALUout = (A+B) mod 256, with CO = bit 8 of the 9-bit sum (unsigned carry out).
REQ-015 SUB SHALL produce ALUout = (A-B) mod 256 in two's complement, with CO = 1 exactly when A < B (unsigned borrow) and CO = 0 when A >= B.
REQ-016 AND and OR SHALL produce bitwise results with CO = 0.
REQ-017 Z SHALL be 1 exactly when the 8-bit ALUout value registered at the same edge is 8'h00, for every opcode; the carry bit SHALL be excluded from the zero test.
REQ-018 Wrap-around SHALL be silent: ADD 255+1 gives ALUout=0, CO=1, Z=1; SUB 0-1 gives ALUout=255, CO=1, Z=0.
REQ-019 Operand changes between clock edges SHALL NOT affect the outputs until the next rising edge (no combinational path from inputs to outputs).
REQ-020 The block SHALL hold no state other than the ALUout, CO and Z registers, and SHALL have no state machine.

Reset
REQ-021 When rst_n is asserted low, ALUout, CO and Z SHALL clear to 0 immediately, without waiting for a clk edge, and SHALL remain 0 while rst_n is low.
REQ-022 After rst_n deasserts, the first rising clk edge SHALL register a normal result from the inputs present at that edge.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; no result from before the reset SHALL appear after it.

Verification
REQ-024 The bench SHALL cover reset: with rst_n=0, any inputs and clock running -> ALUout=0, CO=0, Z=0; releasing rst_n with InsSel=00, A=5, B=5 -> ALUout=10, CO=0, Z=0 one edge later.
REQ-025 The bench SHALL cover SUB with equal operands: InsSel=01, A=5, B=5 -> ALUout=0, CO=0, Z=1.
REQ-026 The bench SHALL cover SUB with A > B and with A < B: InsSel=01, A=8, B=2 -> ALUout=6, CO=0, Z=0; then A=12, B=45 -> ALUout=223 (8'hDF), CO=1, Z=0.
REQ-027 The bench SHALL cover ADD overflow: InsSel=00, A=255, B=1 -> ALUout=0, CO=1, Z=1; A=200, B=100 -> ALUout=44, CO=1, Z=0.
REQ-028 The bench SHALL cover the logic ops: InsSel=10, A=8'hF0, B=8'h0F -> ALUout=0, CO=0, Z=1; InsSel=11, same operands -> ALUout=8'hFF, CO=0, Z=0.
REQ-029 The bench SHALL cover asynchronous reset mid-operation: rst_n pulsed low between clk edges during a stream of ADD operations -> outputs go to 0 before the next edge, and the first post-reset edge shows only the newly sampled result.

Source files
------------

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: ADD/SUB/AND/OR with carry-borrow and zero flags.
// Result is computed combinationally and captured on every rising clk edge.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       InsSel,
  input  logic [WIDTH-1:0] ALUinA,
  input  logic [WIDTH-1:0] ALUinB,
  output logic [WIDTH-1:0] ALUout,
  output logic             CO,
  output logic             Z
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_co;

  logic [WIDTH-1:0] r_out;
  logic             r_co;
  logic             r_z;

  assign w_sum  = {1'b0, ALUinA} + {1'b0, ALUinB};
  // Bit WIDTH of the extended difference is set exactly when A < B (borrow).
  assign w_diff = {1'b0, ALUinA} - {1'b0, ALUinB};

  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    case (InsSel)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_co  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_co  = w_diff[WIDTH];
      end
      OP_AND: w_res = ALUinA & ALUinB;
      OP_OR:  w_res = ALUinA | ALUinB;
      default: begin
        w_res = '0;
        w_co  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_co  <= 1'b0;
      r_z   <= 1'b0;
    end else begin
      r_out <= w_res;
      r_co  <= w_co;
      r_z   <= (w_res == '0);
    end
  end

  assign ALUout = r_out;
  assign CO     = r_co;
  assign Z      = r_z;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed corner cases, async reset
// behaviour and a randomized stream checked against an arithmetic model.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [1:0] InsSel;
  logic [7:0] ALUinA;
  logic [7:0] ALUinB;
  logic [7:0] ALUout;
  logic       CO;
  logic       Z;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_out;
  logic       exp_co;
  logic       exp_z;

  alu_8bit #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .InsSel (InsSel),
    .ALUinA (ALUinA),
    .ALUinB (ALUinB),
    .ALUout (ALUout),
    .CO     (CO),
    .Z      (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode meanings.
  task automatic model(input int sel, input int a, input int b);
    int r;
    int c;
    case (sel)
      0: begin r = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;       end
      2: begin r = a & b;               c = 0;                     end
      default: begin r = a | b;         c = 0;                     end
    endcase
    exp_out = 8'(r);
    exp_co  = (c != 0);
    exp_z   = (r == 0);
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] o, input logic c, input logic z);
    check({tag, ".out"}, {1'b0, ALUout}, {1'b0, o});
    check({tag, ".co"},  {8'b0, CO},     {8'b0, c});
    check({tag, ".z"},   {8'b0, Z},      {8'b0, z});
  endtask

  // Drive one operation between edges, then check it just after the next edge.
  task automatic step(input string tag, input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    InsSel = sel;
    ALUinA = a;
    ALUinB = b;
    @(posedge clk);
    #1;
    model(int'(sel), int'(a), int'(b));
    check_all(tag, exp_out, exp_co, exp_z);
  endtask

  initial begin
    rst_n  = 1'b1;
    InsSel = 2'($urandom_range(3));
    ALUinA = 8'($urandom);
    ALUinB = 8'($urandom);
    #1 rst_n = 1'b0;

    // Reset held with clock running and arbitrary inputs.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    InsSel = 2'b00;
    ALUinA = 8'd5;
    ALUinB = 8'd5;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset_add", 8'd10, 1'b0, 1'b0);

    // Directed corner cases, with literal expectations.
    step("sub_eq",   2'b01, 8'd5,   8'd5);
    check_all("sub_eq_lit", 8'd0, 1'b0, 1'b1);
    step("sub_gt",   2'b01, 8'd8,   8'd2);
    check_all("sub_gt_lit", 8'd6, 1'b0, 1'b0);
    step("sub_lt",   2'b01, 8'd12,  8'd45);
    check_all("sub_lt_lit", 8'hDF, 1'b1, 1'b0);
    step("add_wrap", 2'b00, 8'd255, 8'd1);
    check_all("add_wrap_lit", 8'd0, 1'b1, 1'b1);
    step("add_ovf",  2'b00, 8'd200, 8'd100);
    check_all("add_ovf_lit", 8'd44, 1'b1, 1'b0);
    step("sub_wrap", 2'b01, 8'd0,   8'd1);
    check_all("sub_wrap_lit", 8'hFF, 1'b1, 1'b0);
    step("and_zero", 2'b10, 8'hF0,  8'h0F);
    check_all("and_zero_lit", 8'h00, 1'b0, 1'b1);
    step("or_ones",  2'b11, 8'hF0,  8'h0F);
    check_all("or_ones_lit", 8'hFF, 1'b0, 1'b0);

    // Inputs moving mid-cycle must not reach the outputs before the next edge.
    step("hold_base", 2'b00, 8'd3, 8'd4);
    #2;
    InsSel = 2'b11;
    ALUinA = 8'hAA;
    ALUinB = 8'h55;
    #1;
    check_all("hold_midcycle", 8'd7, 1'b0, 1'b0);

    // Async reset pulsed between edges during an ADD stream.
    step("stream0", 2'b00, 8'd10, 8'd20);
    step("stream1", 2'b00, 8'd30, 8'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst_now", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_all("async_rst_low", 8'h00, 1'b0, 1'b0);
    InsSel = 2'b00;
    ALUinA = 8'd100;
    ALUinB = 8'd27;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    check_all("async_rst_first", 8'd127, 1'b0, 1'b0);

    // Randomized back-to-back operations against the model.
    for (int i = 0; i < 200; i++) begin
      step("rand", 2'($urandom_range(3)), 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
